multicycle_control: RTL and testbench

- Multicycle sequencer for the single-issue datapath: register file, ALU plus ALU control, and data memory.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the datapath strobes one phase at a time.
- Decodes the instruction-set opcodes R, sw, lw, addi and subi; waits on a data-memory ready handshake; counts retired instructions.
- Halts on an illegal opcode or a memory timeout.

---
 rtl/multicycle_control.sv | 169 ++++++++++++++++
 tb/tb_multicycle_control.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Purpose  : FETCH/DECODE/EXEC/MEM/WB sequencer driving single-issue datapath
//            strobes, with memory-ready handshake, timeout and retire counter.
// Revision : 1.0  initial release
// ============================================================================
module multicycle_control #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             write,
    output logic [1:0]       ALUop,
    output logic             ALUsrc,
    output logic             regdst,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic [2:0]       state,
    output logic             illegal,
    output logic             timeout,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [5:0] c_OP_R    = 6'b000000;
    localparam logic [5:0] c_OP_SW   = 6'b010000;
    localparam logic [5:0] c_OP_LW   = 6'b010001;
    localparam logic [5:0] c_OP_ADDI = 6'b001100;
    localparam logic [5:0] c_OP_SUBI = 6'b001101;
    localparam logic [7:0] c_WAIT_LAST = 8'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state, w_state_nxt;
    logic [5:0]       r_op, w_op_nxt;
    logic [7:0]       r_wait, w_wait_nxt;
    logic             r_illegal, w_illegal_nxt;
    logic             r_timeout, w_timeout_nxt;
    logic [CNT_W-1:0] r_count;
    logic             w_retire;
    logic             w_legal;

    assign w_legal = (opcode == c_OP_R)    || (opcode == c_OP_SW) ||
                     (opcode == c_OP_LW)   || (opcode == c_OP_ADDI) ||
                     (opcode == c_OP_SUBI);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_op      <= 6'd0;
            r_wait    <= 8'd0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_op      <= w_op_nxt;
            r_wait    <= w_wait_nxt;
            r_illegal <= w_illegal_nxt;
            r_timeout <= w_timeout_nxt;
            if (w_retire)
                r_count <= r_count + c_CNT_ONE;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_op_nxt      = r_op;
        w_wait_nxt    = r_wait;
        w_illegal_nxt = r_illegal;
        w_timeout_nxt = r_timeout;
        w_retire      = 1'b0;
        case (r_state)
            S_FETCH:  w_state_nxt = S_DECODE;
            S_DECODE: begin
                w_op_nxt = opcode;
                if (w_legal) begin
                    w_state_nxt = S_EXEC;
                end else begin
                    w_state_nxt   = S_HALT;
                    w_illegal_nxt = 1'b1;
                end
            end
            S_EXEC: begin
                w_wait_nxt  = 8'd0;
                w_state_nxt = (r_op == c_OP_LW || r_op == c_OP_SW) ? S_MEM : S_WB;
            end
            S_MEM: begin
                // A ready on the final allowed cycle still completes normally.
                if (mem_ready) begin
                    if (r_op == c_OP_SW) begin
                        w_state_nxt = S_FETCH;
                        w_retire    = 1'b1;
                    end else begin
                        w_state_nxt = S_WB;
                    end
                end else if (r_wait == c_WAIT_LAST) begin
                    w_state_nxt   = S_HALT;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_wait_nxt = r_wait + 8'd1;
                end
            end
            S_WB: begin
                w_state_nxt = S_FETCH;
                w_retire    = 1'b1;
            end
            S_HALT:   w_state_nxt = S_HALT;
            default:  w_state_nxt = S_FETCH;
        endcase
    end

    // Moore output decode; everything is held low while reset is asserted.
    always_comb begin
        pc_write = 1'b0;
        ir_write = 1'b0;
        write    = 1'b0;
        ALUop    = 2'b00;
        ALUsrc   = 1'b0;
        regdst   = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemtoReg = 1'b0;
        if (!rst) begin
            if (r_state == S_FETCH) begin
                pc_write = 1'b1;
                ir_write = 1'b1;
            end
            if (r_state == S_EXEC || r_state == S_MEM || r_state == S_WB) begin
                if (r_op == c_OP_R) begin
                    ALUop  = 2'b10;
                    regdst = 1'b1;
                end else begin
                    ALUop  = (r_op == c_OP_SUBI) ? 2'b01 : 2'b00;
                    ALUsrc = 1'b1;
                end
            end
            if (r_state == S_MEM) begin
                MemRead  = (r_op == c_OP_LW);
                MemWrite = (r_op == c_OP_SW);
            end
            if (r_state == S_WB) begin
                write    = 1'b1;
                MemtoReg = (r_op == c_OP_LW);
            end
        end
    end

    assign state       = r_state;
    assign illegal     = r_illegal;
    assign timeout     = r_timeout;
    assign instr_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Purpose  : Directed self-checking bench for multicycle_control.
// Revision : 1.0  initial release
// ============================================================================
module tb_multicycle_control;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             pc_write, ir_write, write, ALUsrc, regdst;
    logic             MemRead, MemWrite, MemtoReg, illegal, timeout;
    logic [1:0]       ALUop;
    logic [2:0]       state;
    logic [CNT_W-1:0] instr_count;

    int checks = 0;
    int errors = 0;

    multicycle_control #(.MEM_TIMEOUT(16), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .write(write),
        .ALUop(ALUop), .ALUsrc(ALUsrc), .regdst(regdst),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .state(state), .illegal(illegal), .timeout(timeout),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] strobes();
        return {23'd0, pc_write, ir_write, write, ALUop, ALUsrc, regdst,
                MemRead, MemWrite, MemtoReg};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run_r();
        opcode = 6'b000000;
        tick(); tick(); tick(); tick();
    endtask

    initial begin
        rst = 1'b1; opcode = 6'd0; mem_ready = 1'b0;
        tick(); tick();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_strobes", strobes(), 32'd0);
        chk("rst_count", 32'(instr_count), 32'd0);
        chk("rst_flags", {30'd0, illegal, timeout}, 32'd0);
        rst = 1'b0;
        #1;
        chk("fetch_ir_pc", {30'd0, ir_write, pc_write}, 32'd3);

        // R-type
        opcode = 6'b000000;
        tick(); chk("r_decode", 32'(state), 32'd1);
        tick(); chk("r_exec", 32'(state), 32'd2);
        chk("r_exec_ctl", {29'd0, ALUop, regdst}, {29'd0, 2'b10, 1'b1});
        chk("r_exec_alusrc", 32'(ALUsrc), 32'd0);
        tick(); chk("r_wb", 32'(state), 32'd4);
        chk("r_wb_ctl", {30'd0, write, MemtoReg}, 32'd2);
        tick(); chk("r_fetch", 32'(state), 32'd0);
        chk("r_count", 32'(instr_count), 32'd1);

        // lw with three wait cycles
        opcode = 6'b010001; mem_ready = 1'b0;
        tick(); tick();
        chk("lw_exec_ctl", {29'd0, ALUop, ALUsrc}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            mem_ready = (i == 3);
            chk("lw_mem_state", 32'(state), 32'd3);
            chk("lw_memread", {29'd0, MemRead, ALUop}, 32'd4);
        end
        tick(); mem_ready = 1'b0;
        chk("lw_wb", 32'(state), 32'd4);
        chk("lw_wb_ctl", {28'd0, write, MemtoReg, MemRead, regdst}, 32'b1100);
        tick(); chk("lw_count", 32'(instr_count), 32'd2);

        // subi then sw with immediate ready
        opcode = 6'b001101;
        tick(); tick(); chk("subi_aluop", 32'(ALUop), 32'd1);
        tick(); chk("subi_wb", {29'd0, write, ALUop}, 32'b101);
        tick();
        opcode = 6'b010000; mem_ready = 1'b1;
        tick(); tick(); chk("sw_exec_write", 32'(write), 32'd0);
        tick(); chk("sw_mem", {29'd0, state == 3'd3, MemWrite, write}, 32'b110);
        tick(); chk("sw_done", {30'd0, MemWrite, write}, 32'd0);
        chk("sw_state", 32'(state), 32'd0);
        chk("sw_count", 32'(instr_count), 32'd4);

        // sw timeout
        mem_ready = 1'b0;
        tick(); tick(); tick();
        for (int i = 0; i < 16; i++) begin
            chk("to_mem", {30'd0, state == 3'd3, MemWrite}, 32'd3);
            tick();
        end
        chk("to_halt", {29'd0, state}, 32'd5);
        chk("to_flag", 32'(timeout), 32'd1);
        chk("to_strobes", strobes(), 32'd0);
        do_reset();
        chk("to_clear", {30'd0, timeout, illegal}, 32'd0);

        // sw with ready on the 16th MEM cycle
        tick(); tick(); tick();
        for (int i = 0; i < 16; i++) begin
            mem_ready = (i == 15);
            chk("late_mem", 32'(state), 32'd3);
            tick();
        end
        mem_ready = 1'b0;
        chk("late_state", 32'(state), 32'd0);
        chk("late_timeout", 32'(timeout), 32'd0);
        chk("late_count", 32'(instr_count), 32'd1);

        // illegal opcode
        opcode = 6'b111111;
        tick(); tick();
        opcode = 6'b000000;
        chk("ill_state", 32'(state), 32'd5);
        chk("ill_flag", 32'(illegal), 32'd1);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("ill_hold", {28'd0, state, illegal}, {28'd0, 3'd5, 1'b1});
            chk("ill_strobes", strobes(), 32'd0);
        end
        do_reset();
        chk("ill_rst", {28'd0, state, illegal}, 32'd0);

        // reset during lw wait
        run_r();
        chk("pre_abort_count", 32'(instr_count), 32'd1);
        opcode = 6'b010001; mem_ready = 1'b0;
        tick(); tick(); tick(); tick();
        chk("abort_in_mem", {30'd0, state == 3'd3, MemRead}, 32'd3);
        rst = 1'b1;
        #1;
        chk("abort_rst_strobes", strobes(), 32'd0);
        tick();
        chk("abort_state", 32'(state), 32'd0);
        chk("abort_wr", {30'd0, MemRead, write}, 32'd0);
        chk("abort_count", 32'(instr_count), 32'd0);
        rst = 1'b0;

        // counter wrap with 4-bit counter
        for (int i = 0; i < 15; i++) run_r();
        chk("wrap_15", 32'(instr_count), 32'd15);
        run_r();
        chk("wrap_0", 32'(instr_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
